// File: rtl/mmio_bus_arbiter_if.sv
// Signal bundle between the two requesting masters, the arbiter and the shared
// memory-mapped peripheral bus. The arbiter takes the slave side.
interface mmio_bus_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  // Handshake: a master raises mN_req with write/addr/wdata and holds it until
  // mN_ack, a single-cycle pulse that carries mN_err and mN_rdata. Those inputs
  // are captured at grant, so what the master does with them afterwards has no
  // effect on the transaction in flight. bus_ready is only looked at while the
  // arbiter waits on the peripheral.
  logic              m0_req;
  logic              m1_req;
  logic              m0_write;
  logic              m1_write;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic              m0_ack;
  logic              m1_ack;
  logic              m0_err;
  logic              m1_err;
  logic [DATA_W-1:0] m0_rdata;
  logic [DATA_W-1:0] m1_rdata;
  logic [ADDR_W-1:0] bus_address;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_read;
  logic              bus_write;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ready;

  modport slave (
    input  m0_req, m1_req, m0_write, m1_write,
    input  m0_addr, m1_addr, m0_wdata, m1_wdata,
    output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
    output bus_address, bus_wdata, bus_read, bus_write,
    input  bus_rdata, bus_ready
  );

  modport master (
    output m0_req, m1_req, m0_write, m1_write,
    output m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
    input  bus_address, bus_wdata, bus_read, bus_write,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Round-robin two-master arbiter and transaction sequencer for the shared MMIO
// bus. A transaction runs IDLE -> ISSUE -> WAIT -> DONE, and a silent address times out.
module mmio_bus_arbiter #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  mmio_bus_arbiter_if.slave    mbus,
  output logic [1:0]           state_dbg
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              grant;
  logic              grant_nx;
  logic              last_grant;
  logic              lat_write;
  logic [CW-1:0]     wait_cnt;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              err0_q;
  logic              err1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              rd_d;
  logic              wr_d;
  logic              ack0_d;
  logic              ack1_d;
  logic              err_d;
  logic [DATA_W-1:0] res_d;

  logic              take;
  logic              finish;

  assign take   = (state == S_IDLE) && (state_nx == S_ISSUE);
  assign finish = (state == S_WAIT) && (state_nx == S_DONE);

  // Muxes follow the grant being decided this cycle, so capture lands at grant.
  assign sel_write = grant_nx ? mbus.m1_write : mbus.m0_write;
  assign sel_addr  = grant_nx ? mbus.m1_addr  : mbus.m0_addr;
  assign sel_wdata = grant_nx ? mbus.m1_wdata : mbus.m0_wdata;

  // State register, together with the arbitration history.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      if (take) begin
        last_grant <= grant_nx;
      end
    end
  end

  // Next-state and grant decision.
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    case (state)
      S_IDLE: begin
        if (mbus.m0_req || mbus.m1_req) begin
          state_nx = S_ISSUE;
          if (mbus.m0_req && mbus.m1_req) begin
            grant_nx = ~last_grant;
          end else begin
            grant_nx = mbus.m1_req;
          end
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (mbus.bus_ready || (wait_cnt == CNT_LAST)) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode: produces the next value of every registered output.
  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    err_d  = 1'b0;
    res_d  = '0;
    case (state)
      S_IDLE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (take) begin
          rd_d = ~sel_write;
          wr_d = sel_write;
        end
      end
      S_ISSUE: begin
        rd_d = rd_q;
        wr_d = wr_q;
      end
      S_WAIT: begin
        if (finish) begin
          rd_d   = 1'b0;
          wr_d   = 1'b0;
          ack0_d = ~grant;
          ack1_d = grant;
          // A timeout returns all ones on reads; writes never return data.
          if (mbus.bus_ready) begin
            err_d = 1'b0;
            res_d = lat_write ? '0 : mbus.bus_rdata;
          end else begin
            err_d = 1'b1;
            res_d = lat_write ? '0 : '1;
          end
        end
      end
      S_DONE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
      default: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_write <= 1'b0;
      wait_cnt  <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      if (take) begin
        lat_write <= sel_write;
        addr_q    <= sel_addr;
        wdata_q   <= sel_wdata;
      end
      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if ((state == S_WAIT) && (state_nx == S_WAIT)) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= ack0_d & err_d;
      err1_q   <= ack1_d & err_d;
      rdata0_q <= ack0_d ? res_d : '0;
      rdata1_q <= ack1_d ? res_d : '0;
    end
  end

  assign mbus.bus_read    = rd_q;
  assign mbus.bus_write   = wr_q;
  assign mbus.bus_address = addr_q;
  assign mbus.bus_wdata   = wdata_q;
  assign mbus.m0_ack      = ack0_q;
  assign mbus.m1_ack      = ack1_q;
  assign mbus.m0_err      = err0_q;
  assign mbus.m1_err      = err1_q;
  assign mbus.m0_rdata    = rdata0_q;
  assign mbus.m1_rdata    = rdata1_q;
  assign state_dbg        = state;

endmodule
